// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port synchronous data RAM (core M-stage + secondary master).
// Define ARB_ROUND_ROBIN_EN for strict alternation; default is fixed priority with a MAX_BURST starvation limit.
module dmem_arbiter #(
    parameter int AW        = 14,
    parameter int MAX_BURST = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,

    input  logic          p0_req_i,
    input  logic [AW-1:0] p0_addr_i,
    input  logic [31:0]   p0_wdata_i,
    input  logic [3:0]    p0_wmask_i,
    output logic          p0_gnt_o,
    output logic          p0_rvalid_o,
    output logic [31:0]   p0_rdata_o,

    input  logic          p1_req_i,
    input  logic [AW-1:0] p1_addr_i,
    input  logic [31:0]   p1_wdata_i,
    input  logic [3:0]    p1_wmask_i,
    output logic          p1_gnt_o,
    output logic          p1_rvalid_o,
    output logic [31:0]   p1_rdata_o,

    output logic          ram_en_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [31:0]   ram_wdata_o,
    output logic [3:0]    ram_wmask_o,
    input  logic [31:0]   ram_rdata_i
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

    typedef enum logic {
        OWN_P0 = 1'b0,
        OWN_P1 = 1'b1
    } owner_e;

    owner_e        owner_q, owner_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic          p0_rvalid_q, p1_rvalid_q;
    logic          gnt0, gnt1;

    // Grants are held low while reset is asserted so nothing reaches the RAM mid-reset.
    always_comb begin
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        if (rst_ni) begin
            if (p0_req_i && p1_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (owner_q == OWN_P1) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
`else
                if (burst_cnt_q == BURST_MAX) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
`endif
            end else begin
                gnt0 = p0_req_i;
                gnt1 = p1_req_i;
            end

            if (gnt0) begin
                owner_d = OWN_P0;
            end else if (gnt1) begin
                owner_d = OWN_P1;
            end

`ifdef ARB_ROUND_ROBIN_EN
            burst_cnt_d = '0;
`else
            if (gnt1 || !p1_req_i) begin
                burst_cnt_d = '0;
            end else if (gnt0 && (burst_cnt_q != BURST_MAX)) begin
                burst_cnt_d = burst_cnt_q + 1'b1;
            end
`endif
        end
    end

    always_comb begin
        ram_en_o    = gnt0 | gnt1;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_wmask_o = '0;
        if (gnt0) begin
            ram_addr_o  = p0_addr_i;
            ram_wdata_o = p0_wdata_i;
            ram_wmask_o = p0_wmask_i;
        end else if (gnt1) begin
            ram_addr_o  = p1_addr_i;
            ram_wdata_o = p1_wdata_i;
            ram_wmask_o = p1_wmask_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q     <= OWN_P1;
            burst_cnt_q <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            p0_rvalid_q <= gnt0;
            p1_rvalid_q <= gnt1;
        end
    end

    // The RAM returns data one cycle after the access, so the response is steered by last cycle's grant.
    assign p0_gnt_o    = gnt0;
    assign p1_gnt_o    = gnt1;
    assign p0_rvalid_o = p0_rvalid_q;
    assign p1_rvalid_o = p1_rvalid_q;
    assign p0_rdata_o  = p0_rvalid_q ? ram_rdata_i : 32'h0;
    assign p1_rdata_o  = p1_rvalid_q ? ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural read-before-write RAM.
// Covers both the default fixed-priority build and the ARB_ROUND_ROBIN_EN build.
module tb_dmem_arbiter;

    localparam int AW = 14;

    logic          clk;
    logic          rstN;
    logic          p0Req, p1Req;
    logic [AW-1:0] p0Addr, p1Addr;
    logic [31:0]   p0Wdata, p1Wdata;
    logic [3:0]    p0Wmask, p1Wmask;
    logic          p0Gnt, p1Gnt, p0Rvalid, p1Rvalid;
    logic [31:0]   p0Rdata, p1Rdata;
    logic          ramEn;
    logic [AW-1:0] ramAddr;
    logic [31:0]   ramWdata;
    logic [3:0]    ramWmask;
    logic [31:0]   ramRdata;

    logic [31:0]   mem [0:(1<<AW)-1];

    int checks   = 0;
    int failures = 0;

    dmem_arbiter #(.AW(AW), .MAX_BURST(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .p0_req_i    (p0Req),
        .p0_addr_i   (p0Addr),
        .p0_wdata_i  (p0Wdata),
        .p0_wmask_i  (p0Wmask),
        .p0_gnt_o    (p0Gnt),
        .p0_rvalid_o (p0Rvalid),
        .p0_rdata_o  (p0Rdata),
        .p1_req_i    (p1Req),
        .p1_addr_i   (p1Addr),
        .p1_wdata_i  (p1Wdata),
        .p1_wmask_i  (p1Wmask),
        .p1_gnt_o    (p1Gnt),
        .p1_rvalid_o (p1Rvalid),
        .p1_rdata_o  (p1Rdata),
        .ram_en_o    (ramEn),
        .ram_addr_o  (ramAddr),
        .ram_wdata_o (ramWdata),
        .ram_wmask_o (ramWmask),
        .ram_rdata_i (ramRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Old word is captured before the byte-lane write lands.
    always @(posedge clk) begin
        if (ramEn) begin
            ramRdata <= mem[ramAddr];
            for (int b = 0; b < 4; b++) begin
                if (ramWmask[b]) mem[ramAddr][b*8 +: 8] = ramWdata[b*8 +: 8];
            end
        end
    end

    task automatic applyStimulus(input logic r0, input logic [AW-1:0] a0, input logic [31:0] d0,
                                 input logic [3:0] m0, input logic r1, input logic [AW-1:0] a1,
                                 input logic [31:0] d1, input logic [3:0] m1);
        @(negedge clk);
        p0Req = r0; p0Addr = a0; p0Wdata = d0; p0Wmask = m0;
        p1Req = r1; p1Addr = a1; p1Wdata = d1; p1Wmask = m1;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkGrants(input string tag, input logic [1:0] expected);
        checkOutput(tag, {30'h0, p1Gnt, p0Gnt}, {30'h0, expected});
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_gnt"}, {30'h0, p1Gnt, p0Gnt}, 32'h0);
        checkOutput({tag, "_rvalid"}, {30'h0, p1Rvalid, p0Rvalid}, 32'h0);
        checkOutput({tag, "_ram_en"}, {31'h0, ramEn}, 32'h0);
        checkOutput({tag, "_ram_addr"}, {18'h0, ramAddr}, 32'h0);
        checkOutput({tag, "_ram_wdata"}, ramWdata, 32'h0);
        checkOutput({tag, "_ram_wmask"}, {28'h0, ramWmask}, 32'h0);
        checkOutput({tag, "_p0_rdata"}, p0Rdata, 32'h0);
        checkOutput({tag, "_p1_rdata"}, p1Rdata, 32'h0);
    endtask

    initial begin
        logic [1:0] expGnt;
        rstN = 1'b0;
        p0Req = 0; p0Addr = '0; p0Wdata = '0; p0Wmask = '0;
        p1Req = 0; p1Addr = '0; p1Wdata = '0; p1Wmask = '0;
        ramRdata = '0;
        mem[14'h010] = 32'hDEADBEEF;
        mem[14'h005] = 32'h11223344;
        mem[14'h020] = 32'h0;

        // Reset held with both ports requesting: everything must stay quiet.
        applyStimulus(1, 14'h020, 32'h0, 4'h0, 1, 14'h020, 32'h0, 4'h0);
        checkAllZero("reset");
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checkGrants("reset_release_gnt", 2'b01);
        applyStimulus(0, '0, 32'h0, 4'h0, 0, '0, 32'h0, 4'h0);
        checkOutput("reset_release_rvalid", {30'h0, p1Rvalid, p0Rvalid}, 32'h1);
        checkOutput("idle_ram_en", {31'h0, ramEn}, 32'h0);

        // Single p1 read.
        applyStimulus(0, '0, 32'h0, 4'h0, 1, 14'h010, 32'h0, 4'h0);
        checkGrants("p1_read_gnt", 2'b10);
        checkOutput("p1_read_ram_addr", {18'h0, ramAddr}, 32'h10);
        checkOutput("p1_read_ram_wmask", {28'h0, ramWmask}, 32'h0);
        applyStimulus(0, '0, 32'h0, 4'h0, 0, '0, 32'h0, 4'h0);
        checkOutput("p1_read_rvalid", {30'h0, p1Rvalid, p0Rvalid}, 32'h2);
        checkOutput("p1_read_rdata", p1Rdata, 32'hDEADBEEF);
        checkOutput("p1_read_p0_rdata", p0Rdata, 32'h0);
        applyStimulus(0, '0, 32'h0, 4'h0, 0, '0, 32'h0, 4'h0);
        checkOutput("p1_rdata_after", p1Rdata, 32'h0);
        checkOutput("p1_rvalid_after", {31'h0, p1Rvalid}, 32'h0);

        // Both requesting for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 14'h020, 32'h0, 4'h0, 1, 14'h020, 32'h0, 4'h0);
`ifdef ARB_ROUND_ROBIN_EN
            expGnt = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
            expGnt = (i % 5 == 4) ? 2'b10 : 2'b01;
`endif
            checkGrants($sformatf("contend_%0d", i), expGnt);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 14'h020, 32'h0, 4'h0, 0, '0, 32'h0, 4'h0);
            checkGrants($sformatf("p0_alone_%0d", i), 2'b01);
        end

        // Give ownership to p1 so the next contention goes to p0 in either build.
        applyStimulus(0, '0, 32'h0, 4'h0, 1, 14'h010, 32'h0, 4'h0);
        checkGrants("p1_owner_gnt", 2'b10);
        applyStimulus(0, '0, 32'h0, 4'h0, 0, '0, 32'h0, 4'h0);

        // p0 byte write vs p1 read of the same word.
        applyStimulus(1, 14'h005, 32'h00AB0000, 4'b0100, 1, 14'h005, 32'h0, 4'h0);
        checkGrants("wr_rd_gnt0", 2'b01);
        checkOutput("wr_rd_ram_wmask", {28'h0, ramWmask}, 32'h4);
        checkOutput("wr_rd_ram_wdata", ramWdata, 32'h00AB0000);
        applyStimulus(0, '0, 32'h0, 4'h0, 1, 14'h005, 32'h0, 4'h0);
        checkGrants("wr_rd_gnt1", 2'b10);
        checkOutput("wr_rd_p0_rvalid", {31'h0, p0Rvalid}, 32'h1);
        checkOutput("wr_rd_p0_rdata_old", p0Rdata, 32'h11223344);
        applyStimulus(0, '0, 32'h0, 4'h0, 0, '0, 32'h0, 4'h0);
        checkOutput("wr_rd_p1_rvalid", {31'h0, p1Rvalid}, 32'h1);
        checkOutput("wr_rd_p1_rdata_new", p1Rdata, 32'h11AB3344);

        // Grant a p0 read, then assert reset right after the accepting edge.
        applyStimulus(1, 14'h010, 32'h0, 4'h0, 0, '0, 32'h0, 4'h0);
        checkGrants("rst_mid_gnt", 2'b01);
        @(posedge clk);
        #1;
        rstN = 1'b0;
        @(negedge clk);
        checkAllZero("rst_mid");
        p0Req = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checkOutput("rst_mid_rvalid_hold", {30'h0, p1Rvalid, p0Rvalid}, 32'h0);
        applyStimulus(0, '0, 32'h0, 4'h0, 0, '0, 32'h0, 4'h0);
        checkOutput("rst_after_rvalid", {30'h0, p1Rvalid, p0Rvalid}, 32'h0);
        checkOutput("rst_after_p0_rdata", p0Rdata, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
